playfield_mem_arbiter: RTL and testbench
========================================

// Module: playfield_mem_arbiter
// PURPOSE
//   Shares the single-port playfield RAM (one word per row, one bit per cell) between the
//   display scanner, which drives aio[12:5], and the game-logic engine (piece drop, collision, line clear).
//   Grants one RAM access per clock, returns read data with a fixed 1-cycle latency and
//   guarantees the game engine is never starved by continuous display scanning.
// PARAMETERS
//   ROWS            20  playfield rows (RAM depth)
//   COLS            10  playfield columns (RAM word width)
//   DISP_MAX_STREAK 4   max consecutive display grants while game_req pending (>=1)
// PORTS
//   clk_in      in   1        system clock, all logic on rising edge
//   rst         in   1        asynchronous reset, active-high
//   disp_req    in   1        display read request, held until disp_ack
//   disp_row    in   RW       display row address, RW = $clog2(ROWS)
//   disp_ack    out  1        display request granted this cycle
//   disp_valid  out  1        disp_data valid (1 cycle after disp_ack)
//   disp_data   out  COLS     row contents for display
//   game_req    in   1        game request, held until game_ack
//   game_we     in   1        1 = write, 0 = read
//   game_row    in   RW       game row address
//   game_wdata  in   COLS     write data
//   game_ack    out  1        game request granted this cycle
//   game_valid  out  1        game_rdata valid (1 cycle after read ack)
//   game_rdata  out  COLS     read data for game
//   clr_start   in   1        pulse: start full-field clear (optional feature)
//   clr_busy    out  1        clear sweep in progress
// BEHAVIOUR
//   - Reset: all outputs 0, streak counter 0, FSM -> IDLE; pending valids dropped; RAM contents not reset.
//   - Handshake: requester holds req/addr/we/wdata stable until ack; ack is a 1-cycle combinational
//     grant from current req inputs and registered state; the RAM access takes effect at the edge ending the ack cycle.
//   - Read latency: ack in cycle N -> *_valid=1 with data in cycle N+1 only. Write: no valid pulse.
//   - Arbitration: only disp_req -> display; only game_req -> game; both -> display unless
//     streak==DISP_MAX_STREAK, then game. streak++ on each display grant while game_req=1;
//     streak cleared on game grant or when game_req=0. At most one ack per cycle.
//   - Row >= ROWS: still acked; read returns all-zero with normal valid timing; write dropped.
//   - Back-to-back: same requester may be acked on consecutive cycles (new req after ack).
//   - FSM: IDLE (arbitrate) <-> CLEAR (sweep). IDLE->CLEAR on clr_start; CLEAR->IDLE after row ROWS-1.
//   - Reset mid-sweep: back to IDLE, sweep abandoned, partially-cleared rows stay cleared.
// CONFIGURATION
//   TETRIX_FIELD_CLEAR_EN defined: clr_start (sampled in IDLE only; ignored while clr_busy) enters CLEAR;
//     clr_busy=1 for exactly ROWS cycles, writing 0 to rows 0..ROWS-1 ascending, one per cycle;
//     no disp_ack/game_ack during CLEAR; streak held.
//   Undefined: CLEAR state absent, clr_start ignored, clr_busy tied 0; ports remain for pin-compatibility.
// STRUCTURE
//   - tetrix_pkg: ROWS, COLS, RW localparam, FSM state enum (IDLE, CLEAR), grant encoding
//     (GNT_NONE, GNT_DISP, GNT_GAME).
//   - Sub-module playfield_ram: single-port sync RAM, ROWS x COLS, registered read, write-first.
//   - Top: grant logic, streak counter, clear row counter, valid/route pipeline register.
// TESTING
//   - Write game row 3 = 10'h2A5, then display read row 3 -> disp_valid next cycle, disp_data=10'h2A5.
//   - disp_req and game_req held high: grants D,D,D,D,G,D,D,D,D,G (DISP_MAX_STREAK=4).
//   - Game read row 25 (>=ROWS) -> game_ack, then game_valid with game_rdata=0; RAM unchanged.
//   - Fill rows with 10'h3FF, pulse clr_start -> clr_busy 20 cycles, no acks; all rows read 0 after
//     (with macro); without macro clr_busy stays 0, rows still 10'h3FF.
//   - Assert rst during display read ack cycle -> next cycle disp_valid=0, all outputs 0, disp re-acked after release.
//   - clr_start pulsed again mid-sweep -> ignored; clr_busy drops exactly ROWS cycles after first pulse.

Source files
------------

// File: rtl/tetrix_pkg.sv
// Shared playfield geometry, arbiter limits and enums for the
// playfield memory arbiter slice.
package tetrix_pkg;

  localparam int ROWS            = 20;
  localparam int COLS            = 10;
  localparam int RW              = $clog2(ROWS);
  localparam int DISP_MAX_STREAK = 4;
  localparam int SW              = $clog2(DISP_MAX_STREAK + 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_GAME
  } gnt_e;

  function automatic logic row_ok(input logic [RW-1:0] row);
    return row < RW'(ROWS);
  endfunction

endpackage

// File: rtl/playfield_ram.sv
// Single-port playfield RAM, one word per row, registered read,
// write-first on a same-cycle write.
module playfield_ram
  import tetrix_pkg::*;
(
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [RW-1:0]   addr,
  input  logic [COLS-1:0] wdata,
  output logic [COLS-1:0] rdata
);

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata_q   <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/playfield_mem_arbiter.sv
// Display/game arbiter for the playfield RAM with anti-starvation streak.
// Define TETRIX_FIELD_CLEAR_EN to enable the full-field clear sweep.
module playfield_mem_arbiter
  import tetrix_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst,
  input  logic            disp_req,
  input  logic [RW-1:0]   disp_row,
  output logic            disp_ack,
  output logic            disp_valid,
  output logic [COLS-1:0] disp_data,
  input  logic            game_req,
  input  logic            game_we,
  input  logic [RW-1:0]   game_row,
  input  logic [COLS-1:0] game_wdata,
  output logic            game_ack,
  output logic            game_valid,
  output logic [COLS-1:0] game_rdata,
  input  logic            clr_start,
  output logic            clr_busy
);

  gnt_e            gnt;
  logic            busy;
  logic [RW-1:0]   clr_row;
  logic [SW-1:0]   streak_q, streak_d;
  logic            disp_valid_q, disp_valid_d;
  logic            game_valid_q, game_valid_d;
  logic            oor_q, oor_d;
  logic [RW-1:0]   row;
  logic            oor;
  logic            ram_en, ram_we;
  logic [RW-1:0]   ram_addr;
  logic [COLS-1:0] ram_wdata, ram_rdata;

`ifdef TETRIX_FIELD_CLEAR_EN
  state_e        state_q, state_d;
  logic [RW-1:0] clr_row_q, clr_row_d;
  logic          clr_busy_q;

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_row_d = '0;
        end
      end
      CLEAR: begin
        clr_row_d = clr_row_q + 1'b1;
        if (clr_row_q == RW'(ROWS - 1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_row_q  <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_row_q  <= clr_row_d;
      clr_busy_q <= (state_d == CLEAR);
    end
  end

  assign busy     = clr_busy_q;
  assign clr_busy = clr_busy_q;
  assign clr_row  = clr_row_q;
`else
  logic unused_clr;

  assign unused_clr = clr_start;
  assign busy       = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_row    = '0;
`endif

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst && !busy) begin
      unique case (1'b1)
        disp_req && !game_req: gnt = GNT_DISP;
        game_req && !disp_req: gnt = GNT_GAME;
        disp_req && game_req:
          gnt = (streak_q == SW'(DISP_MAX_STREAK)) ? GNT_GAME : GNT_DISP;
        default: gnt = GNT_NONE;
      endcase
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!busy) begin
      if (!game_req || gnt == GNT_GAME)
        streak_d = '0;
      else if (gnt == GNT_DISP)
        streak_d = streak_q + 1'b1;
    end
  end

  assign row = (gnt == GNT_GAME) ? game_row : disp_row;
  assign oor = !row_ok(row);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = row;
    ram_wdata = game_wdata;
    if (busy) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_row;
      ram_wdata = '0;
    end else if (gnt != GNT_NONE && !oor) begin
      ram_en = 1'b1;
      ram_we = (gnt == GNT_GAME) && game_we;
    end
  end

  always_comb begin
    disp_valid_d = (gnt == GNT_DISP);
    game_valid_d = (gnt == GNT_GAME) && !game_we;
    oor_d        = oor;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      streak_q     <= '0;
      disp_valid_q <= 1'b0;
      game_valid_q <= 1'b0;
      oor_q        <= 1'b0;
    end else begin
      streak_q     <= streak_d;
      disp_valid_q <= disp_valid_d;
      game_valid_q <= game_valid_d;
      oor_q        <= oor_d;
    end
  end

  playfield_ram u_ram (
    .clk   (clk_in),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign disp_ack   = (gnt == GNT_DISP);
  assign game_ack   = (gnt == GNT_GAME);
  assign disp_valid = disp_valid_q;
  assign game_valid = game_valid_q;
  assign disp_data  = (disp_valid_q && !oor_q) ? ram_rdata : '0;
  assign game_rdata = (game_valid_q && !oor_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_playfield_mem_arbiter.sv
// Randomized bench for playfield_mem_arbiter against a behavioural
// model of the field contents, grant rule and clear sweep.
module tb_playfield_mem_arbiter;

  localparam int ROWS = 20;
  localparam int MAXS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_req;
  logic [4:0] disp_row;
  logic       disp_ack;
  logic       disp_valid;
  logic [9:0] disp_data;
  logic       game_req;
  logic       game_we;
  logic [4:0] game_row;
  logic [9:0] game_wdata;
  logic       game_ack;
  logic       game_valid;
  logic [9:0] game_rdata;
  logic       clr_start;
  logic       clr_busy;

  int n_chk  = 0;
  int n_pass = 0;

  bit [9:0] m_mem [ROWS];
  int       m_streak;
  int       m_left;
  bit       m_dv, m_gv;
  bit [9:0] m_dd, m_gd;
  bit       last_dack, last_gack, last_busy;

  always #5 clk = ~clk;

  playfield_mem_arbiter dut (
    .clk_in     (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_row   (disp_row),
    .disp_ack   (disp_ack),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_row   (game_row),
    .game_wdata (game_wdata),
    .game_ack   (game_ack),
    .game_valid (game_valid),
    .game_rdata (game_rdata),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit [9:0] rd(input logic [4:0] r);
    return (int'(r) < ROWS) ? m_mem[r] : 10'h000;
  endfunction

  task automatic model_reset();
    m_dv = 0; m_gv = 0; m_dd = '0; m_gd = '0;
    m_streak = 0; m_left = 0;
  endtask

  // One clock: check outputs at negedge, then advance the model.
  task automatic step();
    bit ed, eg, busy;
    @(negedge clk);
    busy = (m_left != 0);
    ed = 0;
    eg = 0;
    if (!busy) begin
      if (disp_req && game_req) begin
        if (m_streak >= MAXS) eg = 1;
        else ed = 1;
      end else begin
        ed = disp_req;
        eg = game_req;
      end
    end
    last_dack = disp_ack;
    last_gack = game_ack;
    last_busy = clr_busy;
    chk("disp_ack", disp_ack, ed);
    chk("game_ack", game_ack, eg);
    chk("disp_valid", disp_valid, m_dv);
    chk("disp_data", disp_data, m_dd);
    chk("game_valid", game_valid, m_gv);
    chk("game_rdata", game_rdata, m_gd);
    chk("clr_busy", clr_busy, busy);
    m_dv = ed;
    m_dd = ed ? rd(disp_row) : 10'h000;
    m_gv = eg && !game_we;
    m_gd = m_gv ? rd(game_row) : 10'h000;
    if (eg && game_we && int'(game_row) < ROWS) m_mem[game_row] = game_wdata;
    if (!busy) begin
      if (eg || !game_req) m_streak = 0;
      else if (ed) m_streak++;
    end
    if (busy) begin
      m_mem[ROWS - m_left] = '0;
      m_left--;
    end
`ifdef TETRIX_FIELD_CLEAR_EN
    else if (clr_start) m_left = ROWS;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic game_op(input bit we, input int row, input logic [9:0] d);
    bit got = 0;
    game_req = 1; game_we = we; game_row = 5'(row); game_wdata = d;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = last_gack;
    end
    game_req = 0;
    chk("game_op_ack", {31'd0, got}, 1);
  endtask

  task automatic disp_read(input int row);
    bit got = 0;
    disp_req = 1; disp_row = 5'(row);
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = last_dack;
    end
    disp_req = 0;
    chk("disp_rd_ack", {31'd0, got}, 1);
  endtask

  initial begin
    bit [9:0] seq;
    int cnt, last;
    rst = 1; disp_req = 0; disp_row = '0; game_req = 0; game_we = 0;
    game_row = '0; game_wdata = '0; clr_start = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_disp_ack", disp_ack, 0);
    chk("rst_game_ack", game_ack, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_game_valid", game_valid, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_game_rdata", game_rdata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    @(posedge clk);
    #1 rst = 0;

    for (int r = 0; r < ROWS; r++) game_op(1, r, 10'($urandom));
    game_op(1, 3, 10'h2A5);
    disp_read(3);
    step();
    chk("row3_readback", m_mem[3], 10'h2A5);

    seq = '0;
    disp_req = 1; disp_row = 5'd3; game_req = 1; game_we = 0; game_row = 5'd7;
    for (int i = 0; i < 10; i++) begin
      step();
      seq[i] = last_gack;
    end
    disp_req = 0; game_req = 0;
    step();
    chk("streak_seq", seq, 10'b1000010000);

    game_op(0, 25, '0);
    step();
    game_op(1, 25, 10'h155);
    game_op(0, 31, '0);
    for (int r = 0; r < ROWS; r++) game_op(1, r, 10'h3FF);
    step();

    clr_start = 1;
    step();
    clr_start = 0;
    cnt = 0; last = 0;
    disp_req = 1; disp_row = 5'd0;
    for (int i = 1; i <= 30; i++) begin
      clr_start = (i == 5);
      step();
      if (last_dack) disp_req = 0;
      if (last_busy) begin
        cnt++;
        last = i;
      end
    end
    clr_start = 0; disp_req = 0;
`ifdef TETRIX_FIELD_CLEAR_EN
    chk("clr_busy_cycles", cnt, ROWS);
    chk("clr_busy_last", last, ROWS);
`else
    chk("clr_busy_cycles", cnt, 0);
`endif
    for (int r = 0; r < ROWS; r++) disp_read(r);
    step();

    disp_req = 1; disp_row = 5'd3; game_req = 0;
    @(negedge clk);
    chk("rst_pre_ack", disp_ack, 1);
    #2 rst = 1;
    @(posedge clk);
    #1;
    chk("rstmid_disp_valid", disp_valid, 0);
    chk("rstmid_disp_ack", disp_ack, 0);
    chk("rstmid_game_ack", game_ack, 0);
    chk("rstmid_disp_data", disp_data, 0);
    chk("rstmid_game_valid", game_valid, 0);
    chk("rstmid_game_rdata", game_rdata, 0);
    chk("rstmid_clr_busy", clr_busy, 0);
    rst = 0;
    model_reset();
    step();
    chk("rst_reack", last_dack, 1);
    disp_req = 0;
    step();

    for (int i = 0; i < 1500; i++) begin
      if (!disp_req || last_dack) begin
        disp_req = 1'($urandom_range(0, 1));
        disp_row = 5'($urandom_range(0, 23));
      end
      if (!game_req || last_gack) begin
        game_req   = 1'($urandom_range(0, 1));
        game_we    = 1'($urandom_range(0, 1));
        game_row   = 5'($urandom_range(0, 23));
        game_wdata = 10'($urandom);
      end
      clr_start = ($urandom_range(0, 63) == 0);
      step();
    end
    disp_req = 0; game_req = 0; clr_start = 0;
    step();
    for (int r = 0; r < ROWS; r++) disp_read(r);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
